// File: rtl/fetch_sched_pkg.sv
// Shared types and constants for the per-thread fetch scheduler.
// Latency: n/a (types only).
// Backpressure: n/a.
package fetch_sched_pkg;

   localparam int NTHREADS = 4;
   localparam int TID_W    = $clog2(NTHREADS);

   typedef logic [TID_W-1:0] threadid_t;
   typedef logic [31:0]      vaddr_t;

   typedef enum logic {
      READY     = 1'b0,
      WAIT_MISS = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/fetch_sched_rr_arbiter.sv
// Round-robin pick: first requester strictly after i_last, wrapping cyclically.
// Latency: purely combinational.
// Backpressure: none; o_grant_valid=0 when no request is raised.
module rr_arbiter #(
   parameter int N = 4,
   parameter int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] i_req,
   input  logic [W-1:0] i_last,
   output logic [W-1:0] o_grant,
   output logic         o_grant_valid
);

   logic [W-1:0] w_idx;

   // Scan from farthest to nearest offset so the nearest requester after i_last wins.
   always_comb begin
      o_grant       = '0;
      o_grant_valid = 1'b0;
      w_idx         = '0;
      for (int k = N; k >= 1; k--) begin
         w_idx = W'((int'(i_last) + k) % N);
         if (i_req[w_idx]) begin
            o_grant       = w_idx;
            o_grant_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fetch_sched.sv
// Per-thread fetch scheduler: holds PC/state per thread, applies fetch outcome, picks next thread RR.
// Latency: outcome of the cycle-t fetch shapes the registered request presented in cycle t+1.
// Backpressure: hazard replays PC, misses park the thread until fill; no eligible thread -> fetch_valid=0.
module fetch_sched
   import fetch_sched_pkg::*;
#(
   parameter vaddr_t BOOT_PC = 32'h0000_1000,
   parameter vaddr_t PC_STEP = 32'd4
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [NTHREADS-1:0] i_thread_en,
   input  logic                i_redirect_valid,
   input  logic [TID_W-1:0]    i_redirect_thread,
   input  logic [31:0]         i_redirect_pc,
   input  logic                i_itlb_miss,
   input  logic                i_icache_miss,
   input  logic                i_isvalid,
   input  logic                i_fill_done,
   input  logic [TID_W-1:0]    i_fill_thread,
   output logic                o_fetch_valid,
   output logic [TID_W-1:0]    o_fetch_thread,
   output logic [31:0]         o_fetch_pc,
   output logic [NTHREADS-1:0] o_thread_waiting
);

   fetch_state_t  r_state [NTHREADS];
   vaddr_t        r_pc    [NTHREADS];
   threadid_t     r_rr_last;
   logic          r_fetch_valid;
   threadid_t     r_fetch_thread;
   vaddr_t        r_fetch_pc;

   fetch_state_t  w_next_state [NTHREADS];
   vaddr_t        w_next_pc    [NTHREADS];
   logic [NTHREADS-1:0] w_eligible;
   threadid_t     w_grant;
   logic          w_grant_valid;
   logic          w_miss;
   logic          w_issue;

   // Outcome signals only mean something while a real request is out.
   always_comb begin
      w_miss  = r_fetch_valid & (i_itlb_miss | i_icache_miss);
      w_issue = r_fetch_valid & ~(i_itlb_miss | i_icache_miss) & i_isvalid;
   end

   // Post-update state/PC per thread: fill wake, then fetch outcome, then redirect overrides PC.
   always_comb begin
      for (int i = 0; i < NTHREADS; i++) begin
         w_next_state[i] = r_state[i];
         w_next_pc[i]    = r_pc[i];
         if (i_fill_done && i_fill_thread == threadid_t'(i) && r_state[i] == WAIT_MISS)
            w_next_state[i] = READY;
         if (r_fetch_thread == threadid_t'(i)) begin
            if (w_miss)
               w_next_state[i] = WAIT_MISS;
            else if (w_issue)
               w_next_pc[i] = r_pc[i] + PC_STEP;
         end
         if (i_redirect_valid && i_redirect_thread == threadid_t'(i))
            w_next_pc[i] = i_redirect_pc;
         w_eligible[i] = i_thread_en[i] & (w_next_state[i] == READY);
      end
   end

   rr_arbiter #(.N(NTHREADS), .W(TID_W)) u_rr (
      .i_req         (w_eligible),
      .i_last        (r_rr_last),
      .o_grant       (w_grant),
      .o_grant_valid (w_grant_valid)
   );

   // Thread state/PC arrays and the registered fetch request.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         for (int i = 0; i < NTHREADS; i++) begin
            r_state[i] <= READY;
            r_pc[i]    <= BOOT_PC;
         end
         r_rr_last      <= threadid_t'(NTHREADS - 1);
         r_fetch_valid  <= 1'b0;
         r_fetch_thread <= '0;
         r_fetch_pc     <= BOOT_PC;
      end else begin
         for (int i = 0; i < NTHREADS; i++) begin
            r_state[i] <= w_next_state[i];
            r_pc[i]    <= w_next_pc[i];
         end
         r_fetch_valid <= w_grant_valid;
         if (w_grant_valid) begin
            r_fetch_thread <= w_grant;
            r_fetch_pc     <= w_next_pc[w_grant];
            r_rr_last      <= w_grant;
         end
      end
   end

   // Waiting mask is a direct view of the registered state array.
   always_comb begin
      for (int i = 0; i < NTHREADS; i++)
         o_thread_waiting[i] = (r_state[i] == WAIT_MISS);
   end

   assign o_fetch_valid  = r_fetch_valid;
   assign o_fetch_thread = r_fetch_thread;
   assign o_fetch_pc     = r_fetch_pc;

endmodule

// File: tb/tb_fetch_sched.sv
module tb_fetch_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  thread_en;
   logic        redirect_valid;
   logic [1:0]  redirect_thread;
   logic [31:0] redirect_pc;
   logic        itlb_miss;
   logic        icache_miss;
   logic        isvalid;
   logic        fill_done;
   logic [1:0]  fill_thread;
   logic        fetch_valid;
   logic [1:0]  fetch_thread;
   logic [31:0] fetch_pc;
   logic [3:0]  thread_waiting;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        v;
      logic [1:0]  t;
      logic [31:0] pc;
      logic [3:0]  w;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   fetch_sched dut (
      .i_clk             (clk),
      .i_rst             (rst),
      .i_thread_en       (thread_en),
      .i_redirect_valid  (redirect_valid),
      .i_redirect_thread (redirect_thread),
      .i_redirect_pc     (redirect_pc),
      .i_itlb_miss       (itlb_miss),
      .i_icache_miss     (icache_miss),
      .i_isvalid         (isvalid),
      .i_fill_done       (fill_done),
      .i_fill_thread     (fill_thread),
      .o_fetch_valid     (fetch_valid),
      .o_fetch_thread    (fetch_thread),
      .o_fetch_pc        (fetch_pc),
      .o_thread_waiting  (thread_waiting)
   );

   task automatic check_now(input string tag, input exp_t e);
      total++;
      assert (fetch_valid === e.v) else begin
         bad++;
         $error("FAIL %s valid: got %0b want %0b", tag, fetch_valid, e.v);
      end
      total++;
      assert (fetch_thread === e.t) else begin
         bad++;
         $error("FAIL %s thread: got %0d want %0d", tag, fetch_thread, e.t);
      end
      total++;
      assert (fetch_pc === e.pc) else begin
         bad++;
         $error("FAIL %s pc: got %h want %h", tag, fetch_pc, e.pc);
      end
      total++;
      assert (thread_waiting === e.w) else begin
         bad++;
         $error("FAIL %s waiting: got %b want %b", tag, thread_waiting, e.w);
      end
   endtask

   // Push expected request for the next edge, clock once, pop and compare, restore pulse inputs.
   task automatic go(input string tag, input logic v, input logic [1:0] t,
                     input logic [31:0] pc, input logic [3:0] w);
      exp_t e;
      exp_t got;
      e.v = v; e.t = t; e.pc = pc; e.w = w;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $error("FAIL %s: scoreboard empty", tag);
      end else begin
         got = sb.pop_front();
         check_now(tag, got);
      end
      redirect_valid = 1'b0;
      itlb_miss      = 1'b0;
      icache_miss    = 1'b0;
      isvalid        = 1'b1;
      fill_done      = 1'b0;
   endtask

   initial begin
      exp_t r;
      rst = 1'b0;
      thread_en = 4'b1111;
      redirect_valid = 1'b0; redirect_thread = 2'd0; redirect_pc = 32'h0;
      itlb_miss = 1'b0; icache_miss = 1'b0; isvalid = 1'b1;
      fill_done = 1'b0; fill_thread = 2'd0;

      #12;
      r.v = 1'b0; r.t = 2'd0; r.pc = 32'h1000; r.w = 4'b0000;
      check_now("reset", r);
      rst = 1'b1;

      // Round robin, all issuing
      go("rr0", 1, 0, 32'h1000, 4'b0000);
      go("rr1", 1, 1, 32'h1000, 4'b0000);
      go("rr2", 1, 2, 32'h1000, 4'b0000);
      go("rr3", 1, 3, 32'h1000, 4'b0000);
      go("rr4", 1, 0, 32'h1004, 4'b0000);
      go("rr5", 1, 1, 32'h1004, 4'b0000);
      go("rr6", 1, 2, 32'h1004, 4'b0000);
      go("rr7", 1, 3, 32'h1004, 4'b0000);
      go("rr8", 1, 0, 32'h1008, 4'b0000);
      go("rr9", 1, 1, 32'h1008, 4'b0000);

      // Thread 1 icache miss parks it
      icache_miss = 1'b1;
      go("miss1", 1, 2, 32'h1008, 4'b0010);
      go("skip1a", 1, 3, 32'h1008, 4'b0010);
      go("skip1b", 1, 0, 32'h100C, 4'b0010);
      // Same-cycle fill makes thread 1 the very next grant
      fill_done = 1'b1; fill_thread = 2'd1;
      go("wake1", 1, 1, 32'h1008, 4'b0000);

      // Thread 2 hazard replay
      go("pre_hz", 1, 2, 32'h100C, 4'b0000);
      isvalid = 1'b0;
      go("hz_rot", 1, 3, 32'h100C, 4'b0000);
      go("hz_t0", 1, 0, 32'h1010, 4'b0000);
      go("hz_t1", 1, 1, 32'h100C, 4'b0000);
      go("hz_rep", 1, 2, 32'h100C, 4'b0000);

      // Redirect of thread 0 while it issues
      go("rd_a", 1, 3, 32'h1010, 4'b0000);
      go("rd_b", 1, 0, 32'h1014, 4'b0000);
      redirect_valid = 1'b1; redirect_thread = 2'd0; redirect_pc = 32'h2000;
      go("rd_c", 1, 1, 32'h1010, 4'b0000);
      go("rd_d", 1, 2, 32'h1010, 4'b0000);
      go("rd_e", 1, 3, 32'h1014, 4'b0000);
      go("rd_pc", 1, 0, 32'h2000, 4'b0000);
      // itlb miss plus redirect on the same thread: parks and takes the new PC
      itlb_miss = 1'b1;
      redirect_valid = 1'b1; redirect_thread = 2'd0; redirect_pc = 32'h3000;
      go("rd_miss", 1, 1, 32'h1014, 4'b0001);

      // Park everyone
      icache_miss = 1'b1;
      go("park1", 1, 2, 32'h1014, 4'b0011);
      icache_miss = 1'b1;
      go("park2", 1, 3, 32'h1018, 4'b0111);
      icache_miss = 1'b1;
      go("allwait", 0, 3, 32'h1018, 4'b1111);
      icache_miss = 1'b1;
      go("idle_hold", 0, 3, 32'h1018, 4'b1111);
      // Wake thread 0 while disabled: no grant
      thread_en = 4'b0000;
      fill_done = 1'b1; fill_thread = 2'd0;
      go("en_off", 0, 3, 32'h1018, 4'b1110);
      thread_en = 4'b0001;
      go("en_one", 1, 0, 32'h3000, 4'b1110);
      go("single", 1, 0, 32'h3004, 4'b1110);

      // Async reset mid-cycle with thread 3 parked
      #2;
      rst = 1'b0;
      #1;
      r.v = 1'b0; r.t = 2'd0; r.pc = 32'h1000; r.w = 4'b0000;
      check_now("async_rst", r);
      #2;
      rst = 1'b1;
      thread_en = 4'b1111;
      go("post_rst0", 1, 0, 32'h1000, 4'b0000);
      go("post_rst1", 1, 1, 32'h1000, 4'b0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
